// File: rtl/uart_pkg.sv
// Shared definitions for the UART subsystem.
//   - FSM state encodings for the receiver
//   - parity mode constants
//   - clog2 helper used to size counters from parameters
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t START     = 3'd1;
  localparam state_t DATA      = 3'd2;
  localparam state_t PARITY    = 3'd3;
  localparam state_t STOP      = 3'd4;
  localparam state_t WAIT_IDLE = 3'd5;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk - destination clock
//   RST - asynchronous active-high reset; both flops load RESET_VAL
//   d   - asynchronous input
//   q   - synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. Samples each bit at mid-period, rejects start
// glitches, checks optional parity and every stop bit.
// Ports:
//   clk        - system clock, rising edge
//   RST        - asynchronous active-high reset
//   rx         - serial line, idles high, asynchronous to clk
//   rx_data    - received word, LSB is the first data bit on the line
//   rx_valid   - one-cycle pulse marking rx_data/parity_err/frame_err valid
//   parity_err - parity mismatch on the frame flagged by rx_valid
//   frame_err  - a stop bit sampled low on the frame flagged by rx_valid
//   busy       - high while the FSM is outside IDLE
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CntW = clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;

  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_param: parameter out of legal range");
  end

  logic rs;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frame_pend_q, frame_pend_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 frame_bad;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .RST (RST),
    .d   (rx),
    .q   (rs)
  );

  // Includes the stop sample being taken this cycle.
  assign frame_bad = frame_pend_q | ~rs;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    par_pend_d   = par_pend_q;
    frame_pend_d = frame_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        if (!rs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rs) begin
            state_d = IDLE;
          end else begin
            state_d      = DATA;
            bit_idx_d    = '0;
            par_acc_d    = 1'b0;
            par_pend_d   = 1'b0;
            frame_pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rs, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rs;
          if (bit_idx_q == DataLast) begin
            bit_idx_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      PARITY: begin
        if (cnt_q == BitLast) begin
          cnt_d      = '0;
          state_d    = STOP;
          par_pend_d = (PARITY_MODE == PARITY_ODD) ? ~(par_acc_q ^ rs) : (par_acc_q ^ rs);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d        = '0;
          frame_pend_d = frame_bad;
          if (bit_idx_q == StopLast) begin
            bit_idx_d    = '0;
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            parity_err_d = par_pend_q;
            frame_err_d  = frame_bad;
            // A low stop bit may be a break; hold off until the line idles.
            state_d      = frame_bad ? WAIT_IDLE : IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      par_pend_q   <= 1'b0;
      frame_pend_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      par_pend_q   <= par_pend_d;
      frame_pend_q <= frame_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) share clk
// and RST, each with its own serial line.
module tb_uart_rx_param;

  localparam int unsigned Clks = 16;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic rx_c = 1'b1;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned cyc = 0;
  int unsigned pulses_a = 0, pulses_b = 0, pulses_c = 0;
  int unsigned pulse_cyc_a = 0;
  int unsigned t0, base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid_a) begin
      pulses_a    <= pulses_a + 1;
      pulse_cyc_a <= cyc;
    end
    if (valid_b) pulses_b <= pulses_b + 1;
    if (valid_c) pulses_c <= pulses_c + 1;
  end

  uart_rx_param #(.CLKS_PER_BIT(Clks), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .RST(RST), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(Clks), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .RST(RST), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  uart_rx_param #(.CLKS_PER_BIT(Clks), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_c (
    .clk(clk), .RST(RST), .rx(rx_c), .rx_data(data_c), .rx_valid(valid_c),
    .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold_bit(input int sel, input logic v);
    drive(sel, v);
    repeat (Clks) @(negedge clk);
  endtask

  // Start bit, data LSB first, optional parity, stop bits (high).
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic par_bit, input int nstop);
    hold_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(sel, data[i]);
    if (par_en) hold_bit(sel, par_bit);
    for (int i = 0; i < nstop; i++) hold_bit(sel, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_a", 32'(data_a), 0);
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_ferr_a", 32'(ferr_a), 0);
    check("rst_perr_b", 32'(perr_b), 0);
    check("rst_busy_c", 32'(busy_c), 0);
    RST = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5, pulse latency 2 + 8 + 9*16 + 1
    base = pulses_a;
    t0   = cyc;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1);
    check("8n1_pulses", pulses_a - base, 1);
    check("8n1_data", 32'(data_a), 32'hA5);
    check("8n1_perr", 32'(perr_a), 0);
    check("8n1_ferr", 32'(ferr_a), 0);
    check("8n1_latency", pulse_cyc_a - t0, 155);
    repeat (Clks) @(negedge clk);

    // 8E1 0x37: five ones, so the correct even parity bit is 1
    base = pulses_b;
    send_frame(1, 9'h037, 8, 1'b1, 1'b1, 1);
    check("8e1_good_data", 32'(data_b), 32'h37);
    check("8e1_good_perr", 32'(perr_b), 0);
    send_frame(1, 9'h037, 8, 1'b1, 1'b0, 1);
    check("8e1_bad_data", 32'(data_b), 32'h37);
    check("8e1_bad_perr", 32'(perr_b), 1);
    check("8e1_bad_ferr", 32'(ferr_b), 0);
    check("8e1_pulses", pulses_b - base, 2);

    // Glitch: 5 low cycles, well short of the half-bit start check
    base = pulses_a;
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", 32'(busy_a), 1);
    @(negedge clk);
    rx_a = 1'b1;
    repeat (Clks / 2 + 3) @(negedge clk);
    check("glitch_busy_lo", 32'(busy_a), 0);
    check("glitch_no_pulse", pulses_a - base, 0);
    repeat (Clks) @(negedge clk);

    // Break: 20 bit times low
    base = pulses_a;
    rx_a = 1'b0;
    repeat (20 * Clks) @(negedge clk);
    check("break_pulses", pulses_a - base, 1);
    check("break_data", 32'(data_a), 0);
    check("break_ferr", 32'(ferr_a), 1);
    check("break_wait_busy", 32'(busy_a), 1);
    rx_a = 1'b1;
    repeat (2 * Clks) @(negedge clk);
    check("break_idle_busy", 32'(busy_a), 0);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1);
    check("after_break_pulses", pulses_a - base, 2);
    check("after_break_data", 32'(data_a), 32'h5A);
    check("after_break_ferr", 32'(ferr_a), 0);

    // 7O2 back to back: 0x41 (two ones -> parity 1), 0x7F (seven ones -> parity 0)
    base = pulses_c;
    send_frame(2, 9'h041, 7, 1'b1, 1'b1, 2);
    check("7o2_first_data", 32'(data_c), 32'h41);
    check("7o2_first_pulse", pulses_c - base, 1);
    send_frame(2, 9'h07F, 7, 1'b1, 1'b0, 2);
    check("7o2_second_data", 32'(data_c), 32'h7F);
    check("7o2_pulses", pulses_c - base, 2);
    check("7o2_perr", 32'(perr_c), 0);
    check("7o2_ferr", 32'(ferr_c), 0);
    repeat (Clks) @(negedge clk);

    // Reset in the middle of data bit 4 of 0xFF
    base = pulses_a;
    hold_bit(0, 1'b0);
    rx_a = 1'b1;
    repeat (4 * Clks + Clks / 2) @(negedge clk);
    check("midrst_busy_before", 32'(busy_a), 1);
    #2 RST = 1'b1;
    #1;
    check("midrst_data", 32'(data_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_valid", 32'(valid_a), 0);
    @(negedge clk);
    RST = 1'b0;
    repeat (2 * Clks) @(negedge clk);
    check("midrst_no_pulse", pulses_a - base, 0);
    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1);
    check("midrst_next_pulse", pulses_a - base, 1);
    check("midrst_next_data", 32'(data_a), 32'h12);
    check("midrst_next_ferr", 32'(ferr_a), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
